// File: rtl/bip_pkg.sv
// Shared constants for the BIP accumulator datapath: opcodes, flag bit
// positions and the control FSM state encoding.
package bip_pkg;

  // Operation codes carried on i_op; anything above OP_MUL is illegal and
  // behaves as a NOP.
  localparam int unsigned OP_NOP  = 32'd0;
  localparam int unsigned OP_LOAD = 32'd1;
  localparam int unsigned OP_ADD  = 32'd2;
  localparam int unsigned OP_SUB  = 32'd3;
  localparam int unsigned OP_AND  = 32'd4;
  localparam int unsigned OP_OR   = 32'd5;
  localparam int unsigned OP_XOR  = 32'd6;
  localparam int unsigned OP_SHL  = 32'd7;
  localparam int unsigned OP_SRA  = 32'd8;
  localparam int unsigned OP_MUL  = 32'd9;

  // Bit positions inside the {Z,N,C,V} flag word.
  localparam int unsigned FLAG_Z = 32'd3;
  localparam int unsigned FLAG_N = 32'd2;
  localparam int unsigned FLAG_C = 32'd1;
  localparam int unsigned FLAG_V = 32'd0;

  // Control FSM: IDLE accepts operations, MUL waits on the multiplier.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Signed overflow of a two-operand add/sub given the operand MSBs and the
  // result MSB. For subtraction pass the inverted B MSB.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb);
    signed_ovf = (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/bip_seq_multiplier.sv
// Iterative shift-add multiplier. Consumes one multiplier bit per cycle for
// exactly NB_DATA cycles and returns the low NB_DATA bits of the product,
// which equal the low bits of the two's-complement product.
module bip_seq_multiplier
  import bip_pkg::*;
#(
  parameter int NB_DATA = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_product
);

  localparam int CW = $clog2(NB_DATA);
  localparam logic [CW-1:0] LAST = CW'(NB_DATA - 1);

  logic               busy_q,   busy_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [NB_DATA-1:0] mcand_q,  mcand_d;
  logic [NB_DATA-1:0] mplier_q, mplier_d;
  logic [NB_DATA-1:0] prod_q,   prod_d;
  logic [NB_DATA-1:0] prod_sum_s;

  // Partial product including this cycle's multiplier bit.
  assign prod_sum_s = prod_q + (mplier_q[0] ? mcand_q : {NB_DATA{1'b0}});

  // Completion is the last iteration; the product is valid on that cycle so
  // the caller can write it on the same edge that ends the operation.
  assign o_busy    = busy_q;
  assign o_done    = busy_q && (count_q == LAST);
  assign o_product = prod_sum_s;

  // Next-state for load and iteration of the shift-add registers.
  always_comb begin
    busy_d   = busy_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (busy_q) begin
      prod_d   = prod_sum_s;
      mcand_d  = {mcand_q[NB_DATA-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[NB_DATA-1:1]};
      if (count_q == LAST) begin
        busy_d  = 1'b0;
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else if (i_start) begin
      busy_d   = 1'b1;
      count_d  = {CW{1'b0}};
      mcand_d  = i_a;
      mplier_d = i_b;
      prod_d   = {NB_DATA{1'b0}};
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers; reset aborts any run in progress.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      busy_q   <= 1'b0;
      count_q  <= {CW{1'b0}};
      mcand_q  <= {NB_DATA{1'b0}};
      mplier_q <= {NB_DATA{1'b0}};
      prod_q   <= {NB_DATA{1'b0}};
    end else begin
      busy_q   <= busy_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/bip_alu_datapath.sv
// BIP accumulator ALU: single-cycle LOAD/arith/logic/shift operations and a
// multi-cycle MUL handed off to the sequential multiplier.
module bip_alu_datapath
  import bip_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_IMM  = 11,
  parameter int NB_OP   = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_OP-1:0]   i_op,
  input  logic               i_sel_b,
  input  logic [NB_IMM-1:0]  i_imm,
  input  logic [NB_DATA-1:0] i_data_mem,
  output logic [NB_DATA-1:0] o_data,
  output logic [3:0]         o_flags,
  output logic               o_done
);

  localparam int SHW = $clog2(NB_DATA);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] acc_q,   acc_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q,  done_d;

  logic               accept_s;
  logic [NB_DATA-1:0] b_s;
  logic [SHW-1:0]     shamt_s;
  logic [NB_DATA:0]   sum_s;
  logic [NB_DATA-1:0] diff_s;
  logic [NB_DATA-1:0] sra_s;
  logic [NB_DATA-1:0] res_s;
  logic               wr_s;
  logic               c_s;
  logic               v_s;
  logic               mul_start_s;
  logic               mul_busy_s;
  logic               mul_done_s;
  logic [NB_DATA-1:0] mul_product_s;

  // Operand B: sign-extended immediate or memory word.
  assign b_s      = i_sel_b ? NB_DATA'($signed(i_imm)) : i_data_mem;
  assign shamt_s  = b_s[SHW-1:0];
  assign sum_s    = {1'b0, acc_q} + {1'b0, b_s};
  assign diff_s   = acc_q - b_s;
  assign sra_s    = $signed(acc_q) >>> shamt_s;

  assign o_ready  = (state_q == ST_IDLE) && !mul_busy_s;
  assign accept_s = i_valid && o_ready;

  assign o_data   = acc_q;
  assign o_flags  = flags_q;
  assign o_done   = done_q;

  bip_seq_multiplier #(
    .NB_DATA (NB_DATA)
  ) u_mul (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_start   (mul_start_s),
    .i_a       (acc_q),
    .i_b       (b_s),
    .o_busy    (mul_busy_s),
    .o_done    (mul_done_s),
    .o_product (mul_product_s)
  );

  // Opcode decode, result selection, flag generation and FSM next state.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    mul_start_s = 1'b0;
    res_s       = acc_q;
    wr_s        = 1'b0;
    c_s         = 1'b0;
    v_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          done_d = 1'b1;
          case (i_op)
            NB_OP'(OP_LOAD): begin
              res_s = b_s;
              wr_s  = 1'b1;
            end
            NB_OP'(OP_ADD): begin
              res_s = sum_s[NB_DATA-1:0];
              wr_s  = 1'b1;
              c_s   = sum_s[NB_DATA];
              v_s   = signed_ovf(acc_q[NB_DATA-1], b_s[NB_DATA-1],
                                 sum_s[NB_DATA-1]);
            end
            NB_OP'(OP_SUB): begin
              res_s = diff_s;
              wr_s  = 1'b1;
              c_s   = (acc_q < b_s);
              v_s   = signed_ovf(acc_q[NB_DATA-1], ~b_s[NB_DATA-1],
                                 diff_s[NB_DATA-1]);
            end
            NB_OP'(OP_AND): begin
              res_s = acc_q & b_s;
              wr_s  = 1'b1;
            end
            NB_OP'(OP_OR): begin
              res_s = acc_q | b_s;
              wr_s  = 1'b1;
            end
            NB_OP'(OP_XOR): begin
              res_s = acc_q ^ b_s;
              wr_s  = 1'b1;
            end
            NB_OP'(OP_SHL): begin
              res_s = acc_q << shamt_s;
              wr_s  = 1'b1;
            end
            NB_OP'(OP_SRA): begin
              res_s = sra_s;
              wr_s  = 1'b1;
            end
            NB_OP'(OP_MUL): begin
              // Pulse comes at retirement, not at acceptance.
              done_d      = 1'b0;
              mul_start_s = 1'b1;
              state_d     = ST_MUL;
            end
            default: begin
              // NOP and illegal opcodes: no write, only the done pulse.
              wr_s = 1'b0;
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          res_s   = mul_product_s;
          wr_s    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wr_s) begin
      acc_d           = res_s;
      flags_d[FLAG_Z] = (res_s == {NB_DATA{1'b0}});
      flags_d[FLAG_N] = res_s[NB_DATA-1];
      flags_d[FLAG_C] = c_s;
      flags_d[FLAG_V] = v_s;
    end else begin
      acc_d   = acc_q;
      flags_d = flags_q;
    end
  end

  // Architectural state: accumulator, flags, FSM state and done pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= {NB_DATA{1'b0}};
      flags_q <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bip_alu_datapath.sv
// Directed bench for bip_alu_datapath with a retirement scoreboard.
module tb_bip_alu_datapath;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_op;
  logic        i_sel_b;
  logic [10:0] i_imm;
  logic [15:0] i_data_mem;
  logic [15:0] o_data;
  logic [3:0]  o_flags;
  logic        o_done;

  int tests_run = 0;
  int tests_failed = 0;
  logic [19:0] exp_q[$];
  logic        run_on = 1'b1;

  bip_alu_datapath #(.NB_DATA(16), .NB_IMM(11), .NB_OP(4)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_sel_b    (i_sel_b),
    .i_imm      (i_imm),
    .i_data_mem (i_data_mem),
    .o_data     (o_data),
    .o_flags    (o_flags),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every o_done pops one expected {data,flags}.
  always @(negedge clk) begin
    if (run_on && o_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(o_done), 32'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("done_data", 32'(o_data), 32'(e[19:4]));
        check("done_flags", 32'(o_flags), 32'(e[3:0]));
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic sel, input logic [10:0] imm,
                       input logic [15:0] mem, input logic push,
                       input logic [15:0] ed, input logic [3:0] ef);
    @(negedge clk);
    i_op = op; i_sel_b = sel; i_imm = imm; i_data_mem = mem; i_valid = 1'b1;
    if (push) exp_q.push_back({ed, ef});
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_op = 4'd0; i_sel_b = 1'b0;
    i_imm = 11'd0; i_data_mem = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_flags", 32'(o_flags), 32'h0);
    check("rst_ready", 32'(o_ready), 32'h1);
    check("rst_done", 32'(o_done), 32'h0);

    // LOAD immediate sign extension.
    do_op(4'd1, 1'b1, 11'h3FF, 16'h0, 1'b1, 16'h03FF, 4'b0000);
    do_op(4'd1, 1'b1, 11'h400, 16'h0, 1'b1, 16'hFC00, 4'b0100);
    // ADD signed overflow, SUB borrow.
    do_op(4'd1, 1'b0, 11'h0, 16'h7FFF, 1'b1, 16'h7FFF, 4'b0000);
    do_op(4'd2, 1'b0, 11'h0, 16'h0001, 1'b1, 16'h8000, 4'b0101);
    do_op(4'd1, 1'b1, 11'h000, 16'h0, 1'b1, 16'h0000, 4'b1000);
    do_op(4'd3, 1'b1, 11'h001, 16'h0, 1'b1, 16'hFFFF, 4'b0110);
    // NOP keeps the non-zero flags.
    do_op(4'd0, 1'b1, 11'h123, 16'h0, 1'b1, 16'hFFFF, 4'b0110);
    // ADD with carry out to zero.
    do_op(4'd2, 1'b1, 11'h001, 16'h0, 1'b1, 16'h0000, 4'b1010);
    // Logic ops.
    do_op(4'd1, 1'b0, 11'h0, 16'hF0F0, 1'b1, 16'hF0F0, 4'b0100);
    do_op(4'd4, 1'b0, 11'h0, 16'hFF00, 1'b1, 16'hF000, 4'b0100);
    do_op(4'd5, 1'b1, 11'h00F, 16'h0, 1'b1, 16'hF00F, 4'b0100);
    do_op(4'd6, 1'b0, 11'h0, 16'hF00F, 1'b1, 16'h0000, 4'b1000);
    // Shifts.
    do_op(4'd1, 1'b0, 11'h0, 16'h8000, 1'b1, 16'h8000, 4'b0100);
    do_op(4'd8, 1'b1, 11'h003, 16'h0, 1'b1, 16'hF000, 4'b0100);
    do_op(4'd1, 1'b1, 11'h001, 16'h0, 1'b1, 16'h0001, 4'b0000);
    do_op(4'd7, 1'b1, 11'h00F, 16'h0, 1'b1, 16'h8000, 4'b0100);
    // Illegal opcode.
    do_op(4'd1, 1'b0, 11'h0, 16'h1234, 1'b1, 16'h1234, 4'b0000);
    do_op(4'hF, 1'b1, 11'h7FF, 16'hFFFF, 1'b1, 16'h1234, 4'b0000);

    // MUL 3 * -5 = -15, with an ADD pulsed mid-operation.
    do_op(4'd1, 1'b1, 11'h003, 16'h0, 1'b1, 16'h0003, 4'b0000);
    do_op(4'd9, 1'b1, 11'h7FB, 16'h0, 1'b1, 16'hFFF1, 4'b0100);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("mul_ready_low", 32'(o_ready), 32'h0);
      check("mul_data_hold", 32'(o_data), 32'h0003);
      if (i == 5) begin
        i_op = 4'd2; i_sel_b = 1'b1; i_imm = 11'h100; i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("mul_ready_back", 32'(o_ready), 32'h1);
    check("mul_result", 32'(o_data), 32'hFFF1);
    check("mul_flags", 32'(o_flags), 32'h4);
    @(negedge clk);
    check("mul_done_single", 32'(o_done), 32'h0);
    check("mul_ignored_add", 32'(o_data), 32'hFFF1);

    // Reset 5 cycles into a MUL aborts it with no done pulse.
    do_op(4'd1, 1'b1, 11'h003, 16'h0, 1'b1, 16'h0003, 4'b0000);
    do_op(4'd9, 1'b1, 11'h005, 16'h0, 1'b0, 16'h0, 4'b0000);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_data", 32'(o_data), 32'h0);
    check("rst_mid_ready", 32'(o_ready), 32'h1);
    check("rst_mid_flags", 32'(o_flags), 32'h0);
    check("rst_mid_done", 32'(o_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_ready", 32'(o_ready), 32'h1);
    check("post_rst_data", 32'(o_data), 32'h0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    run_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bip_alu_datapath.md
BIP_ALU_DATAPATH -- requirements
Module: bip_alu_datapath

Interface
REQ-001 SHALL have parameter NB_DATA, default 16, accumulator/operand width (>=4, power of two).
REQ-002 SHALL have parameter NB_IMM, default 11, immediate width (2..NB_DATA).
REQ-003 SHALL have parameter NB_OP, default 4, opcode width.
REQ-004 SHALL have port i_clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_valid  in  1  operation request.
REQ-007 SHALL have port o_ready  out  1  high when able to accept an operation.
REQ-008 SHALL have port i_op  in  NB_OP  operation code.
REQ-009 SHALL have port i_sel_b  in  1  operand B select: 1 = sign-extended i_imm, 0 = i_data_mem.
REQ-010 SHALL have port i_imm  in  NB_IMM  immediate from control unit.
REQ-011 SHALL have port i_data_mem  in  NB_DATA  word from data memory.
REQ-012 SHALL have port o_data  out  NB_DATA  accumulator value.
REQ-013 SHALL have port o_flags  out  4  {Z,N,C,V}, Z at bit 3.
REQ-014 SHALL have port o_done  out  1  one-cycle pulse after an operation retires.

Function
REQ-015 SHALL accept an operation on a rising edge with i_valid=1 and o_ready=1; i_valid while o_ready=0 is ignored, with no queuing.
REQ-016 SHALL form B at acceptance as i_imm sign-extended to NB_DATA (i_sel_b=1) or i_data_mem (i_sel_b=0).
REQ-017 SHALL decode opcodes: 0 NOP, 1 LOAD (acc<=B), 2 ADD, 3 SUB (acc-B), 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SRA, 9 MUL; 10..max are illegal and behave as NOP.
REQ-018 SHALL take the SHL/SRA shift amount from B[log2(NB_DATA)-1:0]; SRA replicates acc MSB.
REQ-019 SHALL, for opcodes 0..8, write acc and flags on the accepting edge and hold o_ready=1 (one op per cycle sustained).
REQ-020 SHALL, for MUL, capture acc and B, drop o_ready on the accepting edge, iterate shift-add for exactly NB_DATA cycles, write the low NB_DATA bits of the two's-complement product to acc on the final edge, and raise o_ready on that same edge.
REQ-021 SHALL use FSM states IDLE (o_ready=1) and MUL (o_ready=0, count 0..NB_DATA-1); MUL->IDLE when count=NB_DATA-1.
REQ-022 SHALL assert o_done for exactly the cycle after acc write (or after NOP/illegal acceptance); back-to-back single-cycle ops give continuous o_done.
REQ-023 SHALL set Z=(result==0) and N=result MSB for every op that writes acc.
REQ-024 SHALL set C for ADD = unsigned carry-out, C for SUB = borrow (acc<B unsigned), and V = signed overflow for ADD/SUB.
REQ-025 SHALL clear C and V for LOAD, logic, shift and MUL ops.
REQ-026 SHALL leave acc and flags unchanged for NOP and illegal opcodes.
REQ-027 SHALL hold o_data and o_flags stable while MUL is in progress (old values until retirement).

Reset
REQ-028 SHALL, on i_reset, immediately force acc=0, flags=0, state IDLE, count=0, o_ready=1, o_done=0, aborting any MUL with no o_done.

Structure
REQ-029 SHALL take opcode constants, flag bit indices and the FSM state encoding from shared package bip_pkg.
REQ-030 SHALL implement MUL in sub-module bip_seq_multiplier (start/busy/done, NB_DATA parameter, asynchronous active-high reset).

Verification (NB_DATA=16, NB_IMM=11)
REQ-031 SHALL cover: LOAD imm 0x3FF -> acc 0x03FF, flags 0000; LOAD imm 0x400 -> acc 0xFC00, N=1.
REQ-032 SHALL cover: acc 0x7FFF, ADD mem 0x0001 -> 0x8000, N=1, V=1, C=0; acc 0x0000, SUB imm 1 -> 0xFFFF, N=1, C=1, V=0.
REQ-033 SHALL cover: acc 0x0003, MUL imm 0x7FB -> o_ready low 16 cycles, acc 0xFFF1, one o_done; i_valid with ADD pulsed mid-MUL is ignored.
REQ-034 SHALL cover: acc 0x8000, SRA imm 3 -> 0xF000; acc 0x0001, SHL imm 15 -> 0x8000, C=0.
REQ-035 SHALL cover: opcode 0xF with acc 0x1234 -> acc and flags unchanged, o_done pulse.
REQ-036 SHALL cover: i_reset asserted 5 cycles into MUL -> acc 0, o_ready 1 without a clock edge, no o_done.
